// File: rtl/mig_tt_engine_pkg.sv
// +----------------------------------------------------------------------------+
// | mig_pkg: selector constants, program-entry types, state enum, proj().      |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mig_pkg;

  localparam int MIG_NUM_INPUTS = 7;
  localparam int MIG_MAX_GATES  = 16;
  localparam int MIG_TT_BITS    = 1 << MIG_NUM_INPUTS;
  localparam int MIG_SEL_W      = $clog2(1 + MIG_NUM_INPUTS + MIG_MAX_GATES);

  localparam int SEL_CONST0     = 0;
  localparam int SEL_INPUT_BASE = 1;
  localparam int SEL_GATE_BASE  = MIG_NUM_INPUTS + 1;
  localparam int SEL_MAX        = SEL_GATE_BASE + MIG_MAX_GATES - 1;

  typedef struct packed {
    logic                 inv;
    logic [MIG_SEL_W-1:0] sel;
  } operand_t;

  // Operand a occupies the least-significant bits of a program word.
  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } gate_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [MIG_TT_BITS-1:0] proj(input int i);
    logic [MIG_TT_BITS-1:0] v;
    for (int m = 0; m < MIG_TT_BITS; m++) begin
      v[m] = m[i];
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mig_tt_engine_if.sv
// +----------------------------------------------------------------------------+
// | mig_tt_engine_if: program, control and result handshake bundle.            |
// | res_onset exists only with MIG_ONSET_COUNT_EN.   rev 1.0                   |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mig_tt_engine_if
  import mig_pkg::*;
#(
  parameter int NUM_INPUTS = MIG_NUM_INPUTS,
  parameter int MAX_GATES  = MIG_MAX_GATES
);
  localparam int TT_BITS = 1 << NUM_INPUTS;
  localparam int SEL_W   = $clog2(1 + NUM_INPUTS + MAX_GATES);

  logic                             prog_we;
  logic [$clog2(MAX_GATES)-1:0]     prog_addr;
  logic [3*(SEL_W+1)-1:0]           prog_data;
  logic                             start;
  logic [$clog2(MAX_GATES+1)-1:0]   num_gates;
  logic [SEL_W-1:0]                 out_sel;
  logic                             out_inv;
  logic                             busy;
  logic                             res_valid;
  logic                             res_ready;
  logic [TT_BITS-1:0]               res_tt;
  logic                             res_err;
`ifdef MIG_ONSET_COUNT_EN
  logic [$clog2(TT_BITS+1)-1:0]     res_onset;
`endif

  modport master (
    output prog_we, prog_addr, prog_data, start, num_gates, out_sel, out_inv, res_ready,
`ifdef MIG_ONSET_COUNT_EN
    input  res_onset,
`endif
    input  busy, res_valid, res_tt, res_err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, num_gates, out_sel, out_inv, res_ready,
`ifdef MIG_ONSET_COUNT_EN
    output res_onset,
`endif
    output busy, res_valid, res_tt, res_err
  );

endinterface

`default_nettype wire

// File: rtl/mig_tt_engine_maj3_vec.sv
// +----------------------------------------------------------------------------+
// | mig_maj3_vec: bitwise 3-input majority with per-operand inversion.         |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mig_maj3_vec #(
  parameter int W = 128
) (
  input  wire logic [W-1:0] i_a,
  input  wire logic [W-1:0] i_b,
  input  wire logic [W-1:0] i_c,
  input  wire logic         i_inv_a,
  input  wire logic         i_inv_b,
  input  wire logic         i_inv_c,
  output logic      [W-1:0] o_y
);
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_c;

  assign w_a = i_a ^ {W{i_inv_a}};
  assign w_b = i_b ^ {W{i_inv_b}};
  assign w_c = i_c ^ {W{i_inv_c}};
  assign o_y = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);

endmodule

`default_nettype wire

// File: rtl/mig_tt_engine.sv
// +----------------------------------------------------------------------------+
// | mig_tt_engine: loadable MIG program evaluated one gate per cycle into a    |
// | full truth table. Option: MIG_ONSET_COUNT_EN (registered popcount). r1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module mig_tt_engine
  import mig_pkg::*;
#(
  parameter int NUM_INPUTS = MIG_NUM_INPUTS,
  parameter int MAX_GATES  = MIG_MAX_GATES
) (
  input wire logic         clk,
  input wire logic         rst,
  mig_tt_engine_if.slave   io_bus
);
  localparam int TT_BITS = 1 << NUM_INPUTS;
  localparam int SEL_W   = $clog2(1 + NUM_INPUTS + MAX_GATES);
  localparam int AW      = $clog2(MAX_GATES);
  localparam int NG_W    = $clog2(MAX_GATES + 1);
  localparam int PW      = 3 * (SEL_W + 1);
`ifdef MIG_ONSET_COUNT_EN
  localparam bit ONSET_EN = 1'b1;
`else
  localparam bit ONSET_EN = 1'b0;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [PW-1:0]      r_prog [MAX_GATES];
  logic [TT_BITS-1:0] r_gate [MAX_GATES];
  logic [NG_W-1:0]    r_k;
  logic [NG_W-1:0]    r_num;
  logic [SEL_W-1:0]   r_out_sel;
  logic               r_out_inv;
  logic               r_err;
  logic               r_oerr;
  logic               r_drain;

  gate_entry_t        w_entry;
  logic [TT_BITS-1:0] w_maj;
  logic               w_gate_bad;
  logic               w_last;
  logic [TT_BITS-1:0] w_res;

  function automatic logic [TT_BITS-1:0] f_fetch(input logic [SEL_W-1:0] sel);
    int s;
    s = int'(sel);
    if (s >= SEL_GATE_BASE && s <= SEL_MAX) return r_gate[AW'(s - SEL_GATE_BASE)];
    if (s >= SEL_INPUT_BASE && s < SEL_GATE_BASE) return proj(s - SEL_INPUT_BASE);
    return '0;
  endfunction

  // Illegal code, or a gate that is not (yet) evaluated below the limit.
  function automatic logic f_bad(input logic [SEL_W-1:0] sel, input logic [NG_W-1:0] lim);
    int s;
    s = int'(sel);
    return (s > SEL_MAX) || (s >= SEL_GATE_BASE && (s - SEL_GATE_BASE) >= int'(lim));
  endfunction

  assign w_entry    = gate_entry_t'(r_prog[r_k[AW-1:0]]);
  assign w_gate_bad = f_bad(w_entry.a.sel, r_k) | f_bad(w_entry.b.sel, r_k) |
                      f_bad(w_entry.c.sel, r_k);
  assign w_last     = (r_k == r_num - NG_W'(1));

  mig_maj3_vec #(.W(TT_BITS)) u_maj (
    .i_a     (f_fetch(w_entry.a.sel)),
    .i_b     (f_fetch(w_entry.b.sel)),
    .i_c     (f_fetch(w_entry.c.sel)),
    .i_inv_a (w_entry.a.inv),
    .i_inv_b (w_entry.b.inv),
    .i_inv_c (w_entry.c.inv),
    .o_y     (w_maj)
  );

  assign w_res = (r_err | r_oerr) ? '0 : (f_fetch(r_out_sel) ^ {TT_BITS{r_out_inv}});

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          if (int'(io_bus.num_gates) > MAX_GATES)            w_next = ST_DONE;
          else if (io_bus.num_gates == '0 && !ONSET_EN)     w_next = ST_DONE;
          else                                              w_next = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (r_drain || w_gate_bad)       w_next = ST_DONE;
        else if (w_last && !ONSET_EN)    w_next = ST_DONE;
      end
      ST_DONE: begin
        if (io_bus.res_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_GATES; i++) r_prog[i] <= '0;
      r_k       <= '0;
      r_num     <= '0;
      r_out_sel <= '0;
      r_out_inv <= 1'b0;
      r_err     <= 1'b0;
      r_oerr    <= 1'b0;
      r_drain   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.prog_we) r_prog[io_bus.prog_addr] <= io_bus.prog_data;
          if (io_bus.start) begin
            r_num     <= io_bus.num_gates;
            r_out_sel <= io_bus.out_sel;
            r_out_inv <= io_bus.out_inv;
            r_k       <= '0;
            r_err     <= int'(io_bus.num_gates) > MAX_GATES;
            r_oerr    <= f_bad(io_bus.out_sel, io_bus.num_gates);
            r_drain   <= ONSET_EN && (io_bus.num_gates == '0);
          end
        end
        ST_EVAL: begin
          if (!r_drain) begin
            if (w_gate_bad) begin
              r_err <= 1'b1;
            end else begin
              r_k <= r_k + NG_W'(1);
              if (w_last) r_drain <= ONSET_EN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Gate vectors carry no reset; stale entries are never observable.
  always_ff @(posedge clk) begin
    if (r_state == ST_EVAL && !r_drain && !w_gate_bad) r_gate[r_k[AW-1:0]] <= w_maj;
  end

  assign io_bus.busy      = (r_state == ST_EVAL);
  assign io_bus.res_valid = (r_state == ST_DONE);
  assign io_bus.res_err   = (r_state == ST_DONE) & (r_err | r_oerr);
  assign io_bus.res_tt    = (r_state == ST_DONE) ? w_res : '0;

`ifdef MIG_ONSET_COUNT_EN
  localparam int OW = $clog2(TT_BITS + 1);
  logic [OW-1:0] r_onset;

  function automatic logic [OW-1:0] f_popcount(input logic [TT_BITS-1:0] v);
    logic [OW-1:0] c;
    c = '0;
    for (int i = 0; i < TT_BITS; i++) c = c + OW'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                                       r_onset <= '0;
    else if (r_state == ST_IDLE && io_bus.start)   r_onset <= '0;
    else if (r_state == ST_EVAL && r_drain)        r_onset <= f_popcount(w_res);
  end

  assign io_bus.res_onset = r_onset;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mig_tt_engine.sv
// +----------------------------------------------------------------------------+
// | tb_mig_tt_engine: directed scoreboard bench for mig_tt_engine.             |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mig_tt_engine;
  import mig_pkg::*;

`ifdef MIG_ONSET_COUNT_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  typedef struct {
    logic [127:0] tt;
    logic         err;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [17:0] tb_prog [16];

  always #5 clk = ~clk;

  mig_tt_engine_if bus_if ();
  mig_tt_engine u_dut (.clk(clk), .rst(rst), .io_bus(bus_if));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] op(input bit inv, input int sel);
    return {inv, 5'(sel)};
  endfunction

  task automatic wr(input int addr, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = 4'(addr);
    bus_if.prog_data = {c, b, a};
    tb_prog[addr]    = {c, b, a};
    step();
    bus_if.prog_we   = 1'b0;
  endtask

  // Scalar per-minterm reference evaluation of the shadow program.
  function automatic logic [127:0] model(input int n, input int osel, input bit oinv);
    logic [127:0] r;
    logic         g [16];
    r = '0;
    for (int m = 0; m < 128; m++) begin
      logic [2:0] v;
      logic [5:0] o;
      int s;
      for (int j = 0; j < n; j++) begin
        for (int k = 0; k < 3; k++) begin
          o = tb_prog[j][k*6 +: 6];
          s = int'(o[4:0]);
          if (s == 0)      v[k] = 1'b0;
          else if (s <= 7) v[k] = m[s-1];
          else             v[k] = g[s-8];
          v[k] = v[k] ^ o[5];
        end
        g[j] = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
      end
      if (osel == 0)      r[m] = 1'b0;
      else if (osel <= 7) r[m] = m[osel-1];
      else                r[m] = g[osel-8];
      r[m] = r[m] ^ oinv;
    end
    return r;
  endfunction

  task automatic run(input int n, input int osel, input bit oinv, input exp_t e);
    exp_t x;
    int   lat;
    bus_if.num_gates = 5'(n);
    bus_if.out_sel   = 5'(osel);
    bus_if.out_inv   = oinv;
    bus_if.start     = 1'b1;
    sb.push_back(e);
    step();
    bus_if.start = 1'b0;
    lat = 1;
    while (!bus_if.res_valid && lat < 60) begin
      step();
      lat++;
    end
    x = sb.pop_front();
    chk("res_valid_seen", 128'(bus_if.res_valid), 128'(1));
    chk("res_tt", bus_if.res_tt, x.tt);
    chk("res_err", 128'(bus_if.res_err), 128'(x.err));
    chk("latency", 128'(lat), 128'(x.lat));
`ifdef MIG_ONSET_COUNT_EN
    chk("res_onset", 128'(bus_if.res_onset), x.err ? 128'(0) : 128'($countones(x.tt)));
`endif
    if (bus_if.res_ready) begin
      step();
      chk("released", 128'(bus_if.res_valid), 128'(0));
    end
  endtask

  function automatic exp_t mk(input logic [127:0] tt, input logic err, input int lat);
    exp_t e;
    e.tt = tt; e.err = err; e.lat = lat;
    return e;
  endfunction

  initial begin
    logic [127:0] c_e8, c_17, c_f8, c_aa;
    c_e8 = {16{8'hE8}};
    c_17 = {16{8'h17}};
    c_f8 = {16{8'hF8}};
    c_aa = {16{8'hAA}};
    for (int i = 0; i < 16; i++) tb_prog[i] = '0;
    bus_if.prog_we = 0; bus_if.prog_addr = '0; bus_if.prog_data = '0;
    bus_if.start = 0; bus_if.num_gates = '0; bus_if.out_sel = '0;
    bus_if.out_inv = 0; bus_if.res_ready = 1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", 128'(bus_if.busy), 128'(0));
    chk("rst_valid", 128'(bus_if.res_valid), 128'(0));
    chk("rst_err", 128'(bus_if.res_err), 128'(0));
    chk("rst_tt", bus_if.res_tt, 128'(0));

    wr(0, op(0, 1), op(0, 2), op(0, 3));
    run(1, 8, 0, mk(c_e8, 0, 2 + XL));
    run(1, 8, 1, mk(c_17, 0, 2 + XL));

    wr(0, op(0, 1), op(0, 2), op(0, 0));
    wr(1, op(0, 8), op(1, 0), op(0, 3));
    run(2, 9, 0, mk(c_f8, 0, 3 + XL));
    run(1, 9, 0, mk(128'(0), 1, 2 + XL));
    run(2, 30, 0, mk(128'(0), 1, 3 + XL));
    run(0, 1, 0, mk(c_aa, 0, 1 + XL));
    run(17, 8, 0, mk(128'(0), 1, 1));

    wr(0, op(0, 9), op(0, 1), op(0, 2));
    run(2, 9, 0, mk(128'(0), 1, 2));

    wr(0, op(0, 4), op(1, 5), op(0, 7));
    wr(1, op(0, 8), op(1, 6), op(0, 1));
    wr(2, op(1, 9), op(0, 8), op(0, 7));
    run(3, 10, 1, mk(model(3, 10, 1), 0, 4 + XL));

    // Backpressure with ignored start/prog_we while DONE is held.
    wr(0, op(0, 1), op(0, 2), op(0, 0));
    wr(1, op(0, 8), op(1, 0), op(0, 3));
    bus_if.res_ready = 0;
    run(2, 9, 0, mk(c_f8, 0, 3 + XL));
    for (int i = 0; i < 5; i++) begin
      bus_if.start     = (i % 2 == 0);
      bus_if.prog_we   = (i % 2 == 1);
      bus_if.prog_addr = 4'd0;
      bus_if.prog_data = 18'h3FFFF;
      step();
      chk("bp_tt_stable", bus_if.res_tt, c_f8);
      chk("bp_valid_held", 128'(bus_if.res_valid), 128'(1));
    end
    bus_if.prog_we = 0;
    bus_if.start = 1;
    bus_if.res_ready = 1;
    step();
    bus_if.start = 0;
    chk("hs_valid_drop", 128'(bus_if.res_valid), 128'(0));
    step();
    chk("hs_start_ignored", 128'(bus_if.busy), 128'(0));
    run(2, 9, 0, mk(c_f8, 0, 3 + XL));

    // Reset during EVAL gate 1 of a 4-gate program.
    wr(0, op(0, 1), op(0, 2), op(0, 3));
    wr(1, op(0, 8), op(0, 4), op(0, 0));
    wr(2, op(0, 9), op(0, 5), op(1, 0));
    wr(3, op(0, 10), op(0, 8), op(0, 6));
    bus_if.num_gates = 5'd4; bus_if.out_sel = 5'd11; bus_if.out_inv = 0;
    bus_if.start = 1;
    step();
    bus_if.start = 0;
    step();
    chk("eval_busy", 128'(bus_if.busy), 128'(1));
    rst = 1;
    step();
    rst = 0;
    chk("midrst_busy", 128'(bus_if.busy), 128'(0));
    chk("midrst_valid", 128'(bus_if.res_valid), 128'(0));
    for (int i = 0; i < 16; i++) tb_prog[i] = '0;
    run(1, 8, 0, mk(128'(0), 0, 2 + XL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mig_tt_engine.md
Name: mig_tt_engine

Overview:
- Programmable majority-inverter-graph (MIG) evaluator for the Boolean-function classification flow.
- Holds a gate program of up to MAX_GATES 3-input majority gates over NUM_INPUTS primary inputs.
- Computes the full 2^NUM_INPUTS-bit truth table bit-parallel, one gate per cycle, and returns it over a valid/ready handshake.
- Replaces hard-wired per-function majority netlists with one reusable, loadable engine.

Parameters:
NUM_INPUTS, 7, number of primary inputs; TT_BITS = 2**NUM_INPUTS (derived)
MAX_GATES, 16, program memory depth (gates)
SEL_W, $clog2(1+NUM_INPUTS+MAX_GATES) (derived), operand selector width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
prog_we  in  1  program write strobe
prog_addr  in  $clog2(MAX_GATES)  gate index to write
prog_data  in  3*(SEL_W+1)  three operands {inv,sel}; operand 0 in the LSBs
start  in  1  begin evaluation (sampled in IDLE only)
num_gates  in  $clog2(MAX_GATES+1)  gates to evaluate; captured at start
out_sel  in  SEL_W  output signal selector; captured at start
out_inv  in  1  complement output; captured at start
busy  out  1  high in EVAL
res_valid  out  1  result valid
res_ready  in  1  consumer ready
res_tt  out  TT_BITS  truth table; bit m = f(x), where x_i = bit i of m
res_err  out  1  program error flag, qualified by res_valid

Behaviour:
- Selector encoding: 0 = constant 0; 1..NUM_INPUTS = x0..x(N-1) projection vectors; NUM_INPUTS+1+j = gate j. The inv bit complements the operand. Any other value is illegal.
- Gate j value = bitwise MAJ(a,b,c) over TT_BITS-bit vectors, stored in a per-gate vector register.
- States: IDLE, EVAL, DONE.
- IDLE:
  - prog_we writes program entry prog_addr.
  - start captures num_gates, out_sel and out_inv, and clears the gate counter k.
  - If num_gates > MAX_GATES, go to DONE with error. If num_gates = 0, go directly to DONE. Otherwise go to EVAL.
- EVAL: cycle k evaluates gate k.
  - Error if any operand of gate k is an illegal selector or references gate j >= k.
  - On error, abort to DONE with res_err=1.
  - After gate num_gates-1 completes, go to DONE.
- DONE:
  - res_valid=1; res_tt = selected signal, optionally complemented.
  - out_sel referencing gate >= num_gates, or an illegal selector, sets res_err=1.
  - Whenever res_err=1, res_tt=0.
  - Outputs are held stable until res_valid & res_ready, then go to IDLE.
- Latency: start accepted at cycle t -> res_valid at t+num_gates+1 (t+1 when num_gates=0).
- Ignored inputs: start in EVAL or DONE; prog_we in EVAL or DONE (program unchanged). A start in the same cycle as the DONE handshake is ignored.
- Reset, including mid-EVAL:
  - state=IDLE; busy=0, res_valid=0, res_err=0, res_tt=0.
  - All program entries cleared to zero (all operands = constant 0, non-inverted).
  - Gate vector registers are not reset.

Optional Feature:
MIG_ONSET_COUNT_EN
- Defined: adds output res_onset [$clog2(TT_BITS+1)] = popcount(res_tt), valid with res_valid, 0 on reset or error. Popcount is registered; DONE entry is delayed by one cycle, so latency becomes num_gates+2.
- Undefined: port absent; latency as stated above.

Decomposition:
- Package mig_pkg contains:
  - selector constants: SEL_CONST0, SEL_INPUT_BASE, SEL_GATE_BASE
  - operand and gate-entry packed struct typedefs
  - state enum
  - projection-vector function proj(i): bit m = bit i of m
- Sub-module mig_maj3_vec: bitwise majority of three TT_BITS vectors with per-operand inversion; purely combinational, one instance.

Test Plan:
- Single gate: gate0=MAJ(x0,x1,x2), num_gates=1, out_sel=gate0 -> res_tt = 0xE8 repeated 16 times (128 bits), res_err=0, res_valid 2 cycles after start.
- Same program with out_inv=1 -> res_tt = 0x17 repeated 16 times.
- Chain: gate0=MAJ(x0,x1,0)=AND, gate1=MAJ(gate0,~0,x2)=OR, num_gates=2 -> res_tt = 0xF8 repeated 16 times; valid at start+3.
- Forward reference: gate0 references gate1, num_gates=2 -> res_valid=1, res_err=1, res_tt=0. Separately: num_gates=17 -> error one cycle after start.
- Backpressure: hold res_ready=0 for 5 cycles with start and prog_we pulsing -> res_tt stable, program unchanged, next start accepted only after the handshake.
- Reset at EVAL cycle 1 of a 4-gate program -> next cycle busy=0, res_valid=0; a subsequent start with out_sel=gate0 returns all zeros (program cleared).
